// File: rtl/alu_mul_sequencer_if.sv
// Handshake and ALU-sharing bundle between the execute-stage control unit,
// the shared ALU and the shift-add multiplier sequencer.
//   start, flush              : request / synchronous abort from control unit
//   multiplicand, multiplier  : operands (Rn, Rm)
//   alu_a, alu_b, alu_control : sequencer drive onto the shared ALU inputs
//   alu_sel                   : 1 = sequencer owns the ALU input mux
//   alu_result                : combinational ALU result, same cycle
//   busy, done, product       : status and registered result
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  // master: control unit + ALU side
  modport master (
    output start, flush, multiplicand, multiplier, alu_result,
    input  alu_a, alu_b, alu_control, alu_sel, busy, done, product
  );

  // slave: the sequencer
  modport slave (
    input  start, flush, multiplicand, multiplier, alu_result,
    output alu_a, alu_b, alu_control, alu_sel, busy, done, product
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier for LEGv8 MUL. Borrows the execute-stage
// ALU for one ADD (multiplier bit set) or OR-with-zero (bit clear) per cycle
// and returns the low WIDTH bits of the product (sign-agnostic).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_mul_sequencer_if.slave (see interface for signal list)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; ALU released, outputs to the mux held at 0
// S_ITER | one shift-add step per cycle through the shared ALU
// S_DONE | one-cycle done pulse, product presented, then back to idle
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic                 clk,
  input logic                 reset_n,
  alu_mul_sequencer_if.slave  bus
);

  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    count_d         = count_q;
    product_d       = product_q;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = 4'd0;
    bus.alu_sel     = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.product     = product_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.flush && bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.multiplicand;
          mplier_d = bus.multiplier;
          count_d  = '0;
          state_d  = S_ITER;
        end
      end

      S_ITER: begin
        bus.busy    = 1'b1;
        bus.alu_sel = 1'b1;
        bus.alu_a   = acc_q;
        if (mplier_q[0]) begin
          bus.alu_b       = mcand_q;
          bus.alu_control = ALU_ADD;
        end else begin
          // OR with zero lets acc pass through the ALU unchanged
          bus.alu_b       = '0;
          bus.alu_control = ALU_OR;
        end
        acc_d    = bus.alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if ((mplier_q >> 1) == '0 ||
                     count_q == CNT_W'(WIDTH - 1)) begin
          // stop early once no set multiplier bits remain
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bus.busy = 1'b1;
        state_d  = S_IDLE;
        // a flush in this cycle suppresses the result entirely
        if (!bus.flush) begin
          bus.done    = 1'b1;
          bus.product = acc_q;
          product_d   = acc_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam int         W      = 64;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared ALU model
  always_comb begin
    bus.alu_result = '0;
    if (bus.alu_control == OP_ADD)     bus.alu_result = bus.alu_a + bus.alu_b;
    else if (bus.alu_control == OP_OR) bus.alu_result = bus.alu_a | bus.alu_b;
  end

  typedef struct {
    logic [W-1:0] prod;
    int           done_cyc;
    int           iters;
    int           adds;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // reference model: product is plain modular multiplication; step count is
  // one per multiplier bit up to and including its highest set bit
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int s);
    exp_t e;
    int   hi;
    hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    e.prod     = a * b;
    e.iters    = hi + 1;
    e.adds     = $countones(b);
    e.done_cyc = s + e.iters;
    return e;
  endfunction

  // monitor / scoreboard
  int iter_cnt, add_cnt, or_cnt;
  bit bad_unsel;
  initial begin
    iter_cnt = 0; add_cnt = 0; or_cnt = 0; bad_unsel = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        iter_cnt = 0; add_cnt = 0; or_cnt = 0; bad_unsel = 0;
      end else begin
        if (!bus.alu_sel && (bus.alu_a != '0 || bus.alu_b != '0 || bus.alu_control != 4'd0))
          bad_unsel = 1;
        if (bus.alu_sel) begin
          iter_cnt++;
          if (bus.alu_control == OP_ADD)     add_cnt++;
          else if (bus.alu_control == OP_OR) or_cnt++;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("product",     bus.product,      e.prod);
            check("done_cycle",  W'(cyc),          W'(e.done_cyc));
            check("iter_cycles", W'(iter_cnt),     W'(e.iters));
            check("add_ops",     W'(add_cnt),      W'(e.adds));
            check("or_ops",      W'(or_cnt),       W'(e.iters - e.adds));
            check("busy_in_done", {63'd0, bus.busy}, 64'd1);
            check("alu_zero_unsel", {63'd0, bad_unsel}, 64'd0);
          end
          iter_cnt = 0; add_cnt = 0; or_cnt = 0; bad_unsel = 0;
        end else if (!bus.busy) begin
          iter_cnt = 0; add_cnt = 0; or_cnt = 0;
        end
      end
    end
  end

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bit got;
    int s;
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    s = cyc + 1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.done) got = 1;
      else @(negedge clk);
    end
    bus.start = 1'b0;
    if (!got) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {63'd0, bus.busy},    64'd0);
    check({tag, "_done"},    {63'd0, bus.done},    64'd0);
    check({tag, "_alu_sel"}, {63'd0, bus.alu_sel}, 64'd0);
    check({tag, "_product"}, bus.product,          64'd0);
    check({tag, "_alu_a"},   bus.alu_a,            64'd0);
    check({tag, "_alu_b"},   bus.alu_b,            64'd0);
    check({tag, "_alu_ctl"}, W'(bus.alu_control),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, last_prod;
    int s;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // directed cases
    do_mul(64'd7, 64'd6, 0);                      // OR,ADD,ADD -> 42
    do_mul(64'd12345, 64'd0, 0);                  // single OR step
    do_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0);    // -3*5 = -15
    do_mul(64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 0);    // full-length signed case
    do_mul(64'd1, 64'h8000_0000_0000_0000, 0);    // worst-case latency
    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0); // wraparound

    // start held through busy: exactly one done
    do_mul(64'd9, 64'd11, 1);
    repeat (4) @(negedge clk);
    check("hold_start_idle", {63'd0, bus.busy}, 64'd0);

    // flush at ITER cycle 3: no done, product keeps its value
    last_prod = 64'd99;
    do_mul(64'd9, 64'd11, 0);
    @(negedge clk);
    bus.multiplicand = 64'd1234;
    bus.multiplier   = 64'hFF;
    bus.start        = 1'b1;
    @(negedge clk);                 // ITER cycle 1
    bus.start = 1'b0;
    @(negedge clk);                 // ITER cycle 2
    @(negedge clk);                 // ITER cycle 3
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_idle",    {63'd0, bus.busy}, 64'd0);
    check("flush_product", bus.product, last_prod);
    repeat (3) @(negedge clk);
    check("flush_no_done", {63'd0, bus.done}, 64'd0);
    do_mul(64'd1234, 64'hFF, 0);

    // flush has priority over start in idle
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_over_start", {63'd0, bus.busy}, 64'd0);

    // randomized
    for (int n = 0; n < 30; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) b = '0;
      do_mul(a, b, ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset mid-ITER
    @(negedge clk);
    bus.multiplicand = 64'd3;
    bus.multiplier   = 64'h8000_0000_0000_0000;
    bus.start        = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_iter_busy", {63'd0, bus.busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    reset_n = 1'b1;
    do_mul(64'd6, 64'd7, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
